sm_commit_monitor: RTL and testbench

Synthesizable retirement monitor sitting directly downstream of the sm_cpu commit point inside the simulation/FPGA harness around sm_top. It consumes the per-instruction commit stream (pc, instr, register-file write), keeps cycle and retirement counters, shadows the result register (a0/x10), detects the program end (self-loop), and enforces a cycle watchdog. Each retired instruction is pushed into a small trace FIFO with a valid/ready output for a downstream printer or UART.

---
 rtl/sm_commit_monitor.sv | 153 +++++++++++++++
 tb/tb_sm_commit_monitor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sm_commit_monitor.sv
// Retirement monitor for the sm_cpu commit stream: counters, a0 shadow,
// self-loop halt detection, cycle watchdog and a trace FIFO toward a printer.
module sm_commit_monitor #(
   parameter int TIMEOUT_CYCLES = 120,
   parameter int FIFO_DEPTH     = 8,
   parameter int EXPECT_REG     = 10,
   parameter int HALT_REPEAT    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        instrValid,
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   input  logic        rfWe,
   input  logic [4:0]  rfWa,
   input  logic [31:0] rfWd,
   input  logic [31:0] expectValue,
   output logic        trValid,
   input  logic        trReady,
   output logic [31:0] trPc,
   output logic [31:0] trInstr,
   output logic [31:0] trWd,
   output logic [4:0]  trRd,
   output logic        trWe,
   output logic        overflow,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [31:0] cycleCount,
   output logic [31:0] retireCount,
   output logic [31:0] a0Value
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int REC_W = 32 + 32 + 1 + 5 + 32;
   localparam int CNT_W = $clog2(HALT_REPEAT + 1);

   localparam logic [PTR_W:0]  DEPTH_L = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] HALT_L = CNT_W'(HALT_REPEAT);
   localparam logic [31:0]     TMO_L   = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [4:0]      EXP_L   = 5'(EXPECT_REG);

   typedef enum logic [1:0] {IDLE, RUN, HALTED, TIMEOUT} state_t;

   state_t state, state_next;

   logic [31:0]      prev_pc;
   logic [CNT_W-1:0] same_cnt, same_next;

   logic [REC_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W:0]   wr_ptr, rd_ptr;
   logic [REC_W-1:0] head;

   logic running, arm, retire, halt_hit, tmo_hit;
   logic empty, full, push, pop;

   assign running = (state == RUN);
   assign arm     = start && !running;
   assign retire  = running && instrValid;

   // A retirement continues the run only if it repeats the previous pc.
   assign same_next = (pc == prev_pc && same_cnt != '0) ? same_cnt + 1'b1 : CNT_W'(1);
   assign halt_hit  = retire && (same_next == HALT_L);
   assign tmo_hit   = running && (cycleCount == TMO_L);

   assign empty = (wr_ptr == rd_ptr);
   assign full  = ((wr_ptr - rd_ptr) == DEPTH_L);
   assign pop   = !empty && trReady;
   assign push  = retire && (!full || pop);

   // ---------------- state machine ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN: begin
            if (halt_hit)     state_next = HALTED;
            else if (tmo_hit) state_next = TIMEOUT;
         end
         default: begin
            if (start) state_next = RUN;
         end
      endcase
   end

   // ---------------- counters, shadow, halt tracker ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycleCount  <= '0;
         retireCount <= '0;
         a0Value     <= '0;
         overflow    <= 1'b0;
         prev_pc     <= '0;
         same_cnt    <= '0;
      end else if (arm) begin
         cycleCount  <= '0;
         retireCount <= '0;
         a0Value     <= '0;
         overflow    <= 1'b0;
         prev_pc     <= '0;
         same_cnt    <= '0;
      end else if (running) begin
         cycleCount <= cycleCount + 32'd1;
         if (instrValid) begin
            retireCount <= retireCount + 32'd1;
            if (rfWe && rfWa == EXP_L && rfWa != 5'd0) a0Value <= rfWd;
            prev_pc  <= pc;
            same_cnt <= same_next;
            if (full && !pop) overflow <= 1'b1;
         end
      end
   end

   // ---------------- trace FIFO ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (arm) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // When full with a pop, the write lands in the slot being vacated.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[PTR_W-1:0]] <= {pc, instr, rfWe, rfWa, rfWd};
   end

   assign head    = mem[rd_ptr[PTR_W-1:0]];
   assign trValid = !empty;

   // Storage is not reset, so head fields are masked while empty.
   assign trPc    = trValid ? head[101:70] : '0;
   assign trInstr = trValid ? head[69:38]  : '0;
   assign trWe    = trValid ? head[37]     : 1'b0;
   assign trRd    = trValid ? head[36:32]  : '0;
   assign trWd    = trValid ? head[31:0]   : '0;

   // ---------------- status ----------------
   assign done    = (state == HALTED) || (state == TIMEOUT);
   assign timeout = (state == TIMEOUT);
   assign pass    = (state == HALTED) && (a0Value == expectValue);

endmodule

// File: tb/tb_sm_commit_monitor.sv
// Randomized and directed bench for sm_commit_monitor against a queue-based
// behavioural model of the retirement monitor.
module tb_sm_commit_monitor;

   localparam int TMO   = 120;
   localparam int DEPTH = 8;
   localparam int EREG  = 10;
   localparam int HREP  = 2;

   localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2, S_TMO = 3;

   logic        clk = 1'b0;
   logic        rst, start, instrValid, rfWe, trReady;
   logic [31:0] pc, instr, rfWd, expectValue;
   logic [4:0]  rfWa;
   logic        trValid, trWe, overflow, done, pass, timeout;
   logic [31:0] trPc, trInstr, trWd, cycleCount, retireCount, a0Value;
   logic [4:0]  trRd;

   sm_commit_monitor #(
      .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH), .EXPECT_REG(EREG), .HALT_REPEAT(HREP)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .instrValid(instrValid), .pc(pc),
      .instr(instr), .rfWe(rfWe), .rfWa(rfWa), .rfWd(rfWd), .expectValue(expectValue),
      .trValid(trValid), .trReady(trReady), .trPc(trPc), .trInstr(trInstr),
      .trWd(trWd), .trRd(trRd), .trWe(trWe), .overflow(overflow), .done(done),
      .pass(pass), .timeout(timeout), .cycleCount(cycleCount),
      .retireCount(retireCount), .a0Value(a0Value)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] wd;
      logic        we;
      logic [4:0]  rd;
   } rec_t;

   rec_t        q[$];
   int          m_state;
   logic [31:0] m_cyc, m_ret, m_a0, m_prev;
   int          m_same;
   bit          m_ovf;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = S_IDLE;
      m_cyc = 0; m_ret = 0; m_a0 = 0; m_prev = 0; m_same = 0; m_ovf = 0;
      q.delete();
   endtask

   // One clock edge of the monitor, from the input values present before it.
   task automatic model_step();
      int   pre  = q.size();
      bit   pop  = (pre != 0) && trReady;
      bit   halt = 0;
      rec_t r;
      if (start && m_state != S_RUN) begin
         model_reset();
         m_state = S_RUN;
         return;
      end
      if (pop) void'(q.pop_front());
      if (m_state != S_RUN) return;
      if (instrValid) begin
         m_ret++;
         r.pc = pc; r.instr = instr; r.wd = rfWd; r.we = rfWe; r.rd = rfWa;
         if (pre < DEPTH || pop) q.push_back(r);
         else m_ovf = 1;
         if (rfWe && rfWa == EREG) m_a0 = rfWd;
         if (pc == m_prev && m_same != 0) m_same++;
         else begin m_same = 1; m_prev = pc; end
         if (m_same == HREP) halt = 1;
      end
      if (halt) m_state = S_HALT;
      else if (m_cyc == TMO - 1) m_state = S_TMO;
      m_cyc++;
   endtask

   task automatic check_all();
      bit hv = (q.size() != 0);
      chk("trValid", trValid, hv);
      chk("trPc",    trPc,    hv ? q[0].pc    : 32'd0);
      chk("trInstr", trInstr, hv ? q[0].instr : 32'd0);
      chk("trWd",    trWd,    hv ? q[0].wd    : 32'd0);
      chk("trRd",    trRd,    hv ? q[0].rd    : 5'd0);
      chk("trWe",    trWe,    hv ? q[0].we    : 1'b0);
      chk("overflow", overflow, m_ovf);
      chk("done",    done,    m_state == S_HALT || m_state == S_TMO);
      chk("timeout", timeout, m_state == S_TMO);
      chk("pass",    pass,    m_state == S_HALT && m_a0 == expectValue);
      chk("cycleCount",  cycleCount,  m_cyc);
      chk("retireCount", retireCount, m_ret);
      chk("a0Value", a0Value, m_a0);
   endtask

   // Apply one cycle of inputs, clock it, and compare just after the edge.
   task automatic cyc(input bit s, input bit iv, input logic [31:0] p,
                      input bit we, input logic [4:0] wa, input logic [31:0] wd,
                      input bit rdy);
      start = s; instrValid = iv; pc = p; rfWe = we; rfWa = wa; rfWd = wd;
      trReady = rdy; instr = $urandom;
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 0, 5'd0, 32'h0, rdy);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      model_reset();
      check_all();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 0; instrValid = 0; pc = 0; instr = 0; rfWe = 0;
      rfWa = 0; rfWd = 0; trReady = 0; expectValue = 32'h2A;
      #12;
      model_reset();
      check_all();
      rst = 1'b0;
      @(posedge clk);
      #1;

      // five distinct retirements streamed straight out
      cyc(1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) cyc(0, 1, 32'(i * 4), 0, 5'd0, 32'h0, 1);
      idle(3, 1);

      // a0 write then self-loop halt; pass tracks expectValue
      do_reset();
      cyc(1, 0, 0, 0, 0, 0, 1);
      cyc(0, 1, 32'h10, 1, 5'd10, 32'h2A, 1);
      cyc(0, 1, 32'h14, 0, 5'd0, 32'h0, 1);
      cyc(0, 1, 32'h14, 0, 5'd0, 32'h0, 1);
      idle(2, 1);
      expectValue = 32'h2B;
      #1;
      chk("pass_comb", pass, 1'b0);
      idle(2, 1);
      expectValue = 32'h2A;

      // watchdog, then a halt on the very edge the watchdog would fire
      cyc(1, 0, 0, 0, 0, 0, 1);
      idle(TMO + 3, 1);
      cyc(1, 0, 0, 0, 0, 0, 1);
      idle(TMO - 2, 1);
      cyc(0, 1, 32'h40, 0, 5'd0, 32'h0, 1);
      cyc(0, 1, 32'h40, 0, 5'd0, 32'h0, 1);
      idle(2, 1);

      // overflow with a stalled consumer, drain, then push+pop at full
      cyc(1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) cyc(0, 1, 32'h100 + 32'(i * 4), 0, 5'd0, 32'h0, 0);
      idle(10, 1);
      cyc(1, 0, 0, 0, 0, 0, 1);
      do_reset();
      cyc(1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) cyc(0, 1, 32'h200 + 32'(i * 4), 0, 5'd0, 32'h0, 0);
      cyc(0, 1, 32'h300, 1, 5'd3, 32'h1234, 1);
      idle(10, 1);

      // x0 write does not touch the shadow
      cyc(0, 1, 32'h400, 1, 5'd10, 32'h11, 1);
      cyc(0, 1, 32'h404, 1, 5'd0, 32'h55, 1);

      // async reset mid-run with trace pending, then an ignored IDLE write
      for (int i = 0; i < 3; i++) cyc(0, 1, 32'h500 + 32'(i * 4), 0, 5'd0, 32'h0, 0);
      do_reset();
      cyc(0, 1, 32'h600, 1, 5'd10, 32'h77, 1);
      cyc(1, 0, 0, 0, 0, 0, 1);
      idle(3, 1);

      // randomized episodes
      for (int e = 0; e < 25; e++) begin
         expectValue = ($urandom_range(0, 1) != 0) ? 32'h2A : 32'h99;
         cyc(1, 0, 0, 0, 0, 0, 1);
         for (int i = 0; i < 60; i++) begin
            logic [4:0]  wa;
            logic [31:0] wd;
            case ($urandom_range(0, 2))
               0: wa = 5'd0;
               1: wa = 5'd10;
               default: wa = 5'($urandom);
            endcase
            wd = ($urandom_range(0, 1) != 0) ? 32'h2A : $urandom;
            cyc(($urandom_range(0, 29) == 0), ($urandom_range(0, 2) != 0),
                32'($urandom_range(0, 15)) << 2, ($urandom_range(0, 1) != 0), wa, wd,
                ($urandom_range(0, 1) != 0));
         end
         if (e == 12) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
